// File: rtl/pool_window_2x2_pkg.sv
// Shared types and constants for the 2x2 max-pool window path.
package pool_window_2x2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW_EVEN,
        ROW_ODD,
        DRAIN,
        FIN
    } pool_state_t;

    localparam int POOL_DW    = 8;
    localparam int POOL_MAX_W = 32;

endpackage

// File: rtl/pool_line_buf.sv
// One-row pixel buffer; reads the even/odd column pair at the current column.
module pool_line_buf #(
    parameter int MAX_W = 32,
    parameter int DW    = 8,
    parameter int AW    = $clog2(MAX_W)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rd_even,
    output logic [DW-1:0] rd_cur
);

    logic [DW-1:0] mem [MAX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rd_even = mem[{addr[AW-1:1], 1'b0}];
    assign rd_cur  = mem[addr];

endmodule

// File: rtl/pool_window_2x2.sv
// Streaming stride-2 2x2 window generator feeding the max-pool stage.
module pool_window_2x2
    import pool_window_2x2_pkg::*;
#(
    parameter int MAX_W = POOL_MAX_W,
    parameter int DW    = POOL_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    cfg_width,
    input  logic [7:0]    cfg_height,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] num1,
    output logic [DW-1:0] num2,
    output logic [DW-1:0] num3,
    output logic [DW-1:0] num4,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    localparam int AW = $clog2(MAX_W);
    localparam int CW = AW + 1;

    pool_state_t   state;
    logic [CW-1:0] w;
    logic [CW-1:0] col;
    logic [6:0]    hp;
    logic [6:0]    rowp;
    logic [DW-1:0] hold;
    logic [DW-1:0] lb_even;
    logic [DW-1:0] lb_cur;

    logic [7:0]    cw_even;
    logic [CW-1:0] w_eff;
    logic [6:0]    hp_eff;
    logic          acc;
    logic          col_end;
    logic          last_pair;
    logic          out_fire;

    assign cw_even = cfg_width & 8'hFE;
    assign w_eff   = (cw_even > 8'(MAX_W)) ? CW'(MAX_W) : CW'(cw_even);
    assign hp_eff  = 7'(cfg_height >> 1);

    assign busy      = (state != IDLE);
    assign out_fire  = out_valid && out_ready;
    assign in_ready  = ((state == ROW_EVEN) || (state == ROW_ODD))
                     && (!out_valid || out_ready);
    assign acc       = in_valid && in_ready;
    assign col_end   = (col == w - CW'(1));
    assign last_pair = (rowp == hp - 7'd1);

    pool_line_buf #(
        .MAX_W (MAX_W),
        .DW    (DW),
        .AW    (AW)
    ) u_lbuf (
        .clk     (clk),
        .we      (acc && (state == ROW_EVEN)),
        .addr    (col[AW-1:0]),
        .wdata   (in_data),
        .rd_even (lb_even),
        .rd_cur  (lb_cur)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            w         <= '0;
            hp        <= '0;
            col       <= '0;
            rowp      <= '0;
            hold      <= '0;
            num1      <= '0;
            num2      <= '0;
            num3      <= '0;
            num4      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        w    <= w_eff;
                        hp   <= hp_eff;
                        col  <= '0;
                        rowp <= '0;
                        if ((w_eff == '0) || (hp_eff == '0)) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= ROW_EVEN;
                        end
                    end
                end
                ROW_EVEN: begin
                    if (acc) begin
                        if (col_end) begin
                            col   <= '0;
                            state <= ROW_ODD;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                ROW_ODD: begin
                    if (acc) begin
                        // Load overrides the accept-clear above: no bubble.
                        if (!col[0]) begin
                            hold <= in_data;
                        end else begin
                            num1      <= lb_even;
                            num2      <= lb_cur;
                            num3      <= hold;
                            num4      <= in_data;
                            out_valid <= 1'b1;
                            out_last  <= col_end && last_pair;
                        end
                        if (col_end) begin
                            col <= '0;
                            if (last_pair) begin
                                state <= DRAIN;
                            end else begin
                                rowp  <= rowp + 7'd1;
                                state <= ROW_EVEN;
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire && out_last) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pool_window_2x2.sv
// Randomized self-checking bench for pool_window_2x2 against a frame-level model.
module tb_pool_window_2x2;

    localparam int MAXW = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] cfg_width;
    logic [7:0] cfg_height;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [7:0] num3;
    logic [7:0] num4;
    logic       out_last;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pool_window_2x2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .num1       (num1),
        .num2       (num2),
        .num3       (num3),
        .num4       (num4),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " in_ready"}, in_ready, 0);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " nums"}, {num1, num2, num3, num4}, 0);
        check({tag, " out_last"}, out_last, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
    endtask

    // Leaves the bench at #1 after the edge that sampled start.
    task automatic do_start(input int cw, input int ch);
        @(posedge clk);
        #1;
        start      = 1'b1;
        cfg_width  = 8'(cw);
        cfg_height = 8'(ch);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // mode 0: out_ready high, 1: 3-cycle stall per window, 2: random
    task automatic run_frame(input string name, input int cw, input int ch,
                             input bit seq, input int mode, input bit poke);
        logic [7:0]  pix[$];
        logic [31:0] expq[$];
        logic [31:0] ew;
        int w;
        int h;
        int npix;
        int pi;
        int cyc;
        int stall;
        bit fin;
        bit exp_done;

        w = cw & ~1;
        if (w > MAXW) w = MAXW;
        h = ch & ~1;
        npix = w * h;
        for (int i = 0; i < npix; i++) begin
            pix.push_back(seq ? 8'(i) : 8'($urandom));
        end
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                expq.push_back({pix[2*r*w + 2*c], pix[2*r*w + 2*c + 1],
                                pix[(2*r+1)*w + 2*c], pix[(2*r+1)*w + 2*c + 1]});
            end
        end

        do_start(cw, ch);

        if (expq.size() == 0) begin
            @(negedge clk);
            check({name, " degen done"}, done, 1);
            check({name, " degen busy"}, busy, 1);
            @(negedge clk);
            check({name, " degen idle done"}, done, 0);
            check({name, " degen idle busy"}, busy, 0);
            return;
        end

        pi = 0;
        cyc = 0;
        stall = 0;
        fin = 0;
        exp_done = 0;
        while (!fin && cyc < npix * 8 + 100) begin
            in_valid = (pi < npix);
            if (mode == 2 && ($urandom % 4) == 0) in_valid = 1'b0;
            in_data = (pi < npix) ? pix[pi] : 8'h00;
            if (mode == 0) begin
                out_ready = 1'b1;
            end else if (mode == 1) begin
                out_ready = 1'b0;
                if (out_valid) begin
                    if (stall < 3) stall++;
                    else begin
                        out_ready = 1'b1;
                        stall = 0;
                    end
                end
            end else begin
                out_ready = (($urandom % 3) != 0);
            end
            if (poke) begin
                start = (cyc == 5);
                cfg_width = (cyc == 5) ? 8'd2 : 8'(cw);
                cfg_height = (cyc == 5) ? 8'd2 : 8'(ch);
            end

            @(negedge clk);
            if (cyc == 0) check({name, " busy"}, busy, 1);
            if (done || exp_done) begin
                check({name, " done"}, done, exp_done);
                if (done) fin = 1;
            end
            exp_done = 0;
            if (in_valid && in_ready) pi++;
            if (out_valid && !out_ready) check({name, " stall in_ready"}, in_ready, 0);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check({name, " extra window"}, 1, 0);
                end else begin
                    ew = expq.pop_front();
                    check({name, " win"}, {num1, num2, num3, num4}, ew);
                    check({name, " last"}, out_last, expq.size() == 0);
                    if (expq.size() == 0) exp_done = 1;
                end
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (!fin) check({name, " timeout"}, 0, 1);
        check({name, " pixels used"}, pi, npix);
        check({name, " windows left"}, expq.size(), 0);
        @(negedge clk);
        check({name, " busy end"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_width = 8'd0;
        cfg_height = 8'd0;
        in_valid = 1'b0;
        in_data = 8'd0;
        out_ready = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post reset");

        run_frame("4x4", 4, 4, 1, 0, 0);
        run_frame("bp", 4, 4, 1, 1, 0);
        run_frame("odd cfg", 5, 3, 1, 0, 0);
        run_frame("w1", 1, 4, 1, 0, 0);
        run_frame("h1", 6, 1, 1, 0, 0);
        run_frame("maxw", 40, 2, 1, 0, 0);
        run_frame("busy start", 8, 4, 1, 0, 1);

        // Abandon a frame part-way; the next one must start clean.
        do_start(4, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("pre reset out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame("after reset", 4, 4, 1, 0, 0);

        for (int k = 0; k < 6; k++) begin
            run_frame("rand", $urandom_range(2, 40), $urandom_range(2, 8),
                      0, 2, 0);
        end
        run_frame("rand bp", 12, 6, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_window_2x2.md
# pool_window_2x2

Streaming 2x2 window generator for the max-pool path. It accepts an 8-bit feature-map pixel stream in row-major order and buffers one even row in a line buffer. It emits non-overlapping, stride-2 windows as four 8-bit values to the combinational 4-input max stage directly downstream. One frame is processed per `start`, with per-frame width/height configuration.

## Interface
- `MAX_W`, 32: maximum row width in pixels; must be even and ≥ 2.
- `DW`, 8: pixel width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse that latches the cfg and begins a frame; ignored unless IDLE.
- `cfg_width`  in  8  row width in pixels; LSB ignored; clipped to `MAX_W`.
- `cfg_height`  in  8  row count; LSB ignored.
- `in_valid`  in  1  `in_data` valid.
- `in_data`  in  DW  pixel.
- `in_ready`  out  1  pixel accepted when `in_valid && in_ready`.
- `out_valid`  out  1  window valid.
- `out_ready`  in  1  window consumed when `out_valid && out_ready`.
- `num1`..`num4`  out  DW  window as top-left, top-right, bottom-left, bottom-right.
- `out_last`  out  1  marks the final window of the frame; qualified by `out_valid`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse at end of frame.

## Operation
- Effective dimensions: W = min(cfg_width & ~1, MAX_W), H = cfg_height & ~1. Both are latched at `start`.
- States and transitions:
  - IDLE → ROW_EVEN on `start`.
  - IDLE → FIN on `start` if W = 0 or H = 0. No windows are emitted.
  - ROW_EVEN: each accepted pixel at column x is written to `lbuf[x]`. After x = W−1 → ROW_ODD.
  - ROW_ODD, even column x: the pixel is stored in `hold`.
  - ROW_ODD, odd column x: the window is loaded into the output register as num1 = `lbuf[x−1]`, num2 = `lbuf[x]`, num3 = `hold`, num4 = pixel, and `out_valid` is set.
  - ROW_ODD: after x = W−1 → ROW_EVEN. On the last row pair, go to DRAIN instead.
  - DRAIN → FIN when the final window (`out_last` = 1) is accepted.
  - FIN: `done` = 1 for exactly one cycle → IDLE.
- `in_ready` = (state ∈ {ROW_EVEN, ROW_ODD}) && (!`out_valid` || `out_ready`). This is a combinational path from `out_ready`.
- When a window is accepted and a new one is loaded in the same cycle, the output register is overwritten with no bubble.
- Column counter width is clog2(MAX_W)+1. Row-pair counter is 7 bits. Both clear at `start`.
- Data is passed through unmodified; no arithmetic on pixels.
- `start` while `busy` is ignored and has no effect on counters or the cfg.
- Pixels are never dropped and never duplicated. Exactly (W/2)·(H/2) windows are emitted per frame.

## Timing
- Reset values: `in_ready` = 0, `out_valid` = 0, `num1`..`num4` = 0, `out_last` = 0, `busy` = 0, `done` = 0, state = IDLE. `lbuf` contents are don't-care.
- `start` at cycle t: `busy` = 1 and `in_ready` may be 1 from t+1.
- Latency: the bottom-right pixel accepted at edge t gives `out_valid` = 1 after edge t, i.e. one cycle.
- `done` is asserted in the cycle after the last window is accepted. `busy` drops with the next edge.
- Degenerate cfg: `start` at t, `done` at t+1, back in IDLE at t+2.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous). The partial frame is abandoned; the next `start` begins a clean frame.
- Throughput: one pixel per cycle when `out_ready` is held high.

## Structure
- Shared pool package holds:
  - the state enum: IDLE, ROW_EVEN, ROW_ODD, DRAIN, FIN;
  - constants `POOL_DW` = 8 and `POOL_MAX_W` = 32.
- One natural sub-module: `pool_line_buf`, a single-port register array of MAX_W × DW with a registered-address-free combinational read at the write column.
- The FSM, counters and output register live in the top.

## Test plan
- **4x4 frame**, pixels 0..15, `out_ready` = 1 → windows (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15). `out_last` only on the 4th window; `done` one cycle after.
- **Backpressure**: same frame with `out_ready` low for 3 cycles on each window → identical window sequence, `in_ready` low while a window is stalled, no loss or duplication.
- **Degenerate cfg**:
  - `cfg_width` = 5, `cfg_height` = 3 → W = 4, H = 2. Pixels 0..7 give windows (0,1,4,5) and (2,3,6,7).
  - `cfg_width` = 1 → no windows; `done` at t+1.
- **Maximum width**: `cfg_width` = 40, `MAX_W` = 32, H = 2 → 16 windows. Last window is (30,31,62,63) for pixels 0..63.
- **Reset mid-frame**: `rst_n` pulled low after 6 pixels of a 4x4 frame → outputs are 0 immediately. A fresh `start` with pixels 0..15 yields the first-scenario sequence exactly.
- **Start while busy**: `start` pulsed mid-frame with a different cfg → ignored; frame completes per the original cfg.
